// File: rtl/master_req_queue_if.sv
// Core-side request/response and fsm_master_1-side bus bundle for master_req_queue.
interface master_req_queue_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
) ();
    // core request channel
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_cmd;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_wdata;
    // master bus towards fsm_master_1
    logic                  req_m;
    logic                  cmd_m;
    logic [ADDR_WIDTH-1:0] addr_m;
    logic [DATA_WIDTH-1:0] wdata_m;
    // slave return paths
    logic                  ack_1s;
    logic                  ack_2s;
    logic [DATA_WIDTH-1:0] rdata_1s;
    logic [DATA_WIDTH-1:0] rdata_2s;
    // core response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_cmd;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    // queue side
    modport master (
        input  in_valid, in_cmd, in_addr, in_wdata,
        input  ack_1s, ack_2s, rdata_1s, rdata_2s,
        input  rsp_ready,
        output in_ready,
        output req_m, cmd_m, addr_m, wdata_m,
        output rsp_valid, rsp_cmd, rsp_rdata, rsp_err
    );

    // core / slave-path side
    modport slave (
        output in_valid, in_cmd, in_addr, in_wdata,
        output ack_1s, ack_2s, rdata_1s, rdata_2s,
        output rsp_ready,
        input  in_ready,
        input  req_m, cmd_m, addr_m, wdata_m,
        input  rsp_valid, rsp_cmd, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/master_req_queue.sv
// Request front end for one crossbar master port: FIFO-buffers core
// transactions, issues them one at a time and returns data or timeout error.
module master_req_queue #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input logic           clock,
    input logic           reset,
    master_req_queue_if.master bus
);
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TMR_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef struct packed {
        logic                  cmd;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } entry_t;

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    entry_t mem [DEPTH];

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  in_ready_q, in_ready_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic                  req_q, req_d;
    logic                  cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_cmd_q, rsp_cmd_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    entry_t                head;
    logic                  head_ack;
    logic                  sel_ack;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  push;
    logic                  pop;

    // Head-of-queue ack guard and in-flight slave selection by address MSB
    always_comb begin
        head      = mem[rd_ptr_q];
        head_ack  = head.addr[ADDR_WIDTH-1] ? bus.ack_2s : bus.ack_1s;
        sel_ack   = addr_q[ADDR_WIDTH-1] ? bus.ack_2s : bus.ack_1s;
        sel_rdata = addr_q[ADDR_WIDTH-1] ? bus.rdata_2s : bus.rdata_1s;
        push      = bus.in_valid & in_ready_q;
    end

    // Next-state, FIFO bookkeeping and registered output values
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tmr_d       = tmr_q;
        req_d       = req_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_cmd_d   = rsp_cmd_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                // launch only once the target slave has dropped any previous ack
                if (count_q != '0 && !head_ack) begin
                    pop     = 1'b1;
                    state_d = REQ;
                    req_d   = 1'b1;
                    cmd_d   = head.cmd;
                    addr_d  = head.addr;
                    wdata_d = head.wdata;
                    tmr_d   = '0;
                end
            end
            REQ: begin
                if (sel_ack) begin
                    state_d     = RSP;
                    req_d       = 1'b0;
                    cmd_d       = 1'b0;
                    addr_d      = '0;
                    wdata_d     = '0;
                    rsp_valid_d = 1'b1;
                    rsp_cmd_d   = cmd_q;
                    rsp_rdata_d = cmd_q ? '0 : sel_rdata;
                    rsp_err_d   = 1'b0;
                end else if (TIMEOUT != 0 && tmr_q == TMR_W'(TMR_LAST)) begin
                    state_d     = RSP;
                    req_d       = 1'b0;
                    cmd_d       = 1'b0;
                    addr_d      = '0;
                    wdata_d     = '0;
                    rsp_valid_d = 1'b1;
                    rsp_cmd_d   = cmd_q;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        in_ready_d = (count_d < CNT_W'(DEPTH));
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            tmr_q       <= '0;
            req_q       <= 1'b0;
            cmd_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_cmd_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            tmr_q       <= tmr_d;
            req_q       <= req_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_cmd_q   <= rsp_cmd_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // FIFO storage; validity is tracked by the pointers alone
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= entry_t'({bus.in_cmd, bus.in_addr, bus.in_wdata});
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.req_m     = req_q;
    assign bus.cmd_m     = cmd_q;
    assign bus.addr_m    = addr_q;
    assign bus.wdata_m   = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_cmd   = rsp_cmd_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_master_req_queue.sv
// Directed self-checking bench for master_req_queue (TIMEOUT=8).
module tb_master_req_queue;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    master_req_queue_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

    master_req_queue #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(4), .TIMEOUT(8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (bus.req_m !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_eq(tag, 64'(bus.req_m), 64'd1);
    endtask

    task automatic push(input logic cmd, input logic [15:0] addr, input logic [31:0] wdata);
        bus.in_valid = 1'b1;
        bus.in_cmd   = cmd;
        bus.in_addr  = addr;
        bus.in_wdata = wdata;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic respond_ack();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int accepted;
        int n;
        bus.in_valid  = 1'b0;
        bus.in_cmd    = 1'b0;
        bus.in_addr   = '0;
        bus.in_wdata  = '0;
        bus.ack_1s    = 1'b0;
        bus.ack_2s    = 1'b0;
        bus.rdata_1s  = '0;
        bus.rdata_2s  = '0;
        bus.rsp_ready = 1'b0;

        // reset state
        #12;
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst_req_m", 64'(bus.req_m), 64'd0);
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("rst_addr_m", 64'(bus.addr_m), 64'd0);
        reset = 1'b1;
        tick();

        // single write to slave 1
        push(1'b1, 16'h0001, 32'h12345678);
        check_eq("wr_req_early", 64'(bus.req_m), 64'd0);
        tick();
        check_eq("wr_req_m", 64'(bus.req_m), 64'd1);
        check_eq("wr_addr_m", 64'(bus.addr_m), 64'h0001);
        check_eq("wr_wdata_m", 64'(bus.wdata_m), 64'h12345678);
        check_eq("wr_cmd_m", 64'(bus.cmd_m), 64'd1);
        bus.ack_1s   = 1'b1;
        bus.rdata_1s = 32'hFFFF0000;
        tick();
        bus.ack_1s = 1'b0;
        check_eq("wr_req_drop", 64'(bus.req_m), 64'd0);
        check_eq("wr_addr_zero", 64'(bus.addr_m), 64'd0);
        check_eq("wr_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check_eq("wr_rsp_cmd", 64'(bus.rsp_cmd), 64'd1);
        check_eq("wr_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        check_eq("wr_rsp_err", 64'(bus.rsp_err), 64'd0);
        tick();
        check_eq("wr_rsp_hold", 64'(bus.rsp_valid), 64'd1);
        respond_ack();
        check_eq("wr_rsp_done", 64'(bus.rsp_valid), 64'd0);

        // read routed to slave 2 with spurious slave-1 ack
        push(1'b0, 16'h8001, 32'h0);
        tick();
        check_eq("rd_req_m", 64'(bus.req_m), 64'd1);
        bus.ack_1s = 1'b1;
        tick();
        bus.ack_1s = 1'b0;
        check_eq("rd_ignore_ack1", 64'(bus.req_m), 64'd1);
        check_eq("rd_no_rsp", 64'(bus.rsp_valid), 64'd0);
        bus.ack_2s   = 1'b1;
        bus.rdata_2s = 32'h12345678;
        bus.rdata_1s = 32'hDEADBEEF;
        tick();
        bus.ack_2s = 1'b0;
        check_eq("rd_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check_eq("rd_rsp_rdata", 64'(bus.rsp_rdata), 64'h12345678);
        check_eq("rd_rsp_cmd", 64'(bus.rsp_cmd), 64'd0);
        respond_ack();

        // back-pressure: 6 back-to-back pushes, 1 launches and 4 queue
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_cmd   = 1'b1;
            bus.in_addr  = 16'(3 + i);
            bus.in_wdata = 32'(32'hA0 + i);
            if (bus.in_ready) accepted++;
            check_eq($sformatf("full_in_ready_%0d", i), 64'(bus.in_ready), (i < 5) ? 64'd1 : 64'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        check_eq("full_accepted", 64'(accepted), 64'd5);
        for (int k = 0; k < 5; k++) begin
            wait_req($sformatf("full_wait_%0d", k));
            check_eq($sformatf("full_addr_%0d", k), 64'(bus.addr_m), 64'(3 + k));
            check_eq($sformatf("full_wdata_%0d", k), 64'(bus.wdata_m), 64'(32'hA0 + k));
            bus.ack_1s = 1'b1;
            tick();
            bus.ack_1s = 1'b0;
            check_eq($sformatf("full_rsp_%0d", k), 64'(bus.rsp_valid), 64'd1);
            respond_ack();
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("full_drained", 64'(bus.req_m), 64'd0);
        end

        // ack-still-high guard
        push(1'b1, 16'h0001, 32'h11);
        push(1'b1, 16'h0002, 32'h22);
        wait_req("guard_first");
        check_eq("guard_first_addr", 64'(bus.addr_m), 64'h0001);
        bus.ack_1s = 1'b1;
        tick();
        check_eq("guard_rsp", 64'(bus.rsp_valid), 64'd1);
        respond_ack();
        check_eq("guard_hold1", 64'(bus.req_m), 64'd0);
        tick();
        check_eq("guard_hold2", 64'(bus.req_m), 64'd0);
        bus.ack_1s = 1'b0;
        tick();
        check_eq("guard_launch", 64'(bus.req_m), 64'd1);
        check_eq("guard_addr", 64'(bus.addr_m), 64'h0002);
        bus.ack_1s = 1'b1;
        tick();
        bus.ack_1s = 1'b0;
        respond_ack();

        // timeout on slave 2, then next queued entry completes
        bus.rdata_2s = 32'h5555AAAA;
        push(1'b0, 16'h8005, 32'h0);
        push(1'b1, 16'h0009, 32'h99);
        check_eq("to_req_m", 64'(bus.req_m), 64'd1);
        check_eq("to_addr", 64'(bus.addr_m), 64'h8005);
        n = 1;
        while (bus.req_m === 1'b1 && n < 20) begin
            tick();
            if (bus.req_m === 1'b1) n++;
        end
        check_eq("to_req_cycles", 64'(n), 64'd8);
        check_eq("to_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check_eq("to_rsp_err", 64'(bus.rsp_err), 64'd1);
        check_eq("to_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        respond_ack();
        check_eq("to_err_clear", 64'(bus.rsp_err), 64'd0);
        wait_req("to_next_wait");
        check_eq("to_next_addr", 64'(bus.addr_m), 64'h0009);
        bus.ack_1s = 1'b1;
        tick();
        bus.ack_1s = 1'b0;
        check_eq("to_next_err", 64'(bus.rsp_err), 64'd0);
        check_eq("to_next_valid", 64'(bus.rsp_valid), 64'd1);
        respond_ack();

        // asynchronous reset mid-REQ with two entries queued
        push(1'b1, 16'h0010, 32'h1);
        push(1'b1, 16'h0011, 32'h2);
        push(1'b1, 16'h0012, 32'h3);
        check_eq("ar_req_before", 64'(bus.req_m), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check_eq("ar_req_m", 64'(bus.req_m), 64'd0);
        check_eq("ar_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("ar_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq($sformatf("ar_idle_%0d", k), 64'(bus.req_m), 64'd0);
        end
        push(1'b1, 16'h0020, 32'h4);
        tick();
        check_eq("ar_new_req", 64'(bus.req_m), 64'd1);
        check_eq("ar_new_addr", 64'(bus.addr_m), 64'h0020);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
